// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - operator front end that loads A/B/Select from switches and runs the ALU handshake
module alu_operand_loader #(
  parameter int DEB_CYCLES = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Btn_n,
  input  logic [3:0] Sw,
  input  logic [1:0] Sel_sw,
  input  logic       Done,
  input  logic [7:0] Alu_sal,
  input  logic       Alu_cout,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [1:0] Select,
  output logic       Init,
  output logic [7:0] Result,
  output logic       Result_cout,
  output logic       Result_valid,
  output logic       Error,
  output logic [2:0] State
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GOT_A = 3'd1,
    S_GOT_B = 3'd2,
    S_RUN   = 3'd3,
    S_SHOW  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          press_q, press_d;

  state_t        state_q, state_d;
  logic [3:0]    a_q, a_d, b_q, b_d;
  logic [1:0]    sel_q, sel_d;
  logic          init_q, init_d;
  logic [7:0]    res_q, res_d;
  logic          cout_q, cout_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      stable_q  <= 1'b1;
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
    end else begin
      sync1_q   <= Btn_n;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      deb_cnt_q <= deb_cnt_d;
      press_q   <= press_d;
    end
  end

  // The stable level flips only after DEB_CYCLES back-to-back disagreeing samples.
  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = '0;
    press_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
        stable_d = sync2_q;
        press_d  = ~sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      init_q  <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      init_q  <= init_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    res_d   = res_q;
    cout_d  = cout_q;
    valid_d = valid_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: if (press_q) begin
        state_d = S_GOT_A;
        a_d     = Sw;
        valid_d = 1'b0;
        err_d   = 1'b0;
      end
      S_GOT_A: if (press_q) begin
        state_d = S_GOT_B;
        b_d     = Sw;
      end
      S_GOT_B: if (press_q) begin
        state_d = S_RUN;
        sel_d   = Sel_sw;
        tmo_d   = '0;
      end
      S_RUN: begin
        // tmo_q == 0 marks the first RUN cycle, where a Done left over from before is ignored.
        if (tmo_q != '0 && Done) begin
          state_d = S_SHOW;
          res_d   = Alu_sal;
          cout_d  = Alu_cout;
          valid_d = 1'b1;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_SHOW: if (press_q) begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
      S_ERR: if (press_q) begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    init_d = (state_d == S_RUN);
  end

  assign A            = a_q;
  assign B            = b_q;
  assign Select       = sel_q;
  assign Init         = init_q;
  assign Result       = res_q;
  assign Result_cout  = cout_q;
  assign Result_valid = valid_q;
  assign Error        = err_q;
  assign State        = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - directed table-driven bench for alu_operand_loader
module tb_alu_operand_loader;

  logic       Clk;
  logic       Rst_n;
  logic       Btn_n;
  logic [3:0] Sw;
  logic [1:0] Sel_sw;
  logic       Done = 1'b0;
  logic [7:0] Alu_sal;
  logic       Alu_cout;
  logic [3:0] A, B;
  logic [1:0] Select;
  logic       Init;
  logic [7:0] Result;
  logic       Result_cout;
  logic       Result_valid;
  logic       Error;
  logic [2:0] State;

  alu_operand_loader dut (
    .Clk(Clk), .Rst_n(Rst_n), .Btn_n(Btn_n), .Sw(Sw), .Sel_sw(Sel_sw),
    .Done(Done), .Alu_sal(Alu_sal), .Alu_cout(Alu_cout),
    .A(A), .B(B), .Select(Select), .Init(Init), .Result(Result),
    .Result_cout(Result_cout), .Result_valid(Result_valid), .Error(Error), .State(State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // mode: 0 = Done never, 1 = Done pulse in RUN cycle done_at, 2 = Done held high
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] sel;
    logic [7:0] sal;
    logic       cout;
    int         mode;
    int         done_at;
    logic [2:0] exp_state;
    int         exp_len;
  } vec_t;

  vec_t vecs [7];
  int   mode    = 0;
  int   done_at = 0;
  int   run_cyc = 0;
  int   n_vec   = 0;
  int   n_fail  = 0;
  logic [7:0] exp_res;
  logic       exp_cout;

  // ALU model: counts RUN cycles from Init and raises Done mid-cycle so the DUT sees it at the cycle end.
  always @(negedge Clk) begin
    if (State == 3'd0) run_cyc <= 0;
    else if (Init) run_cyc <= run_cyc + 1;
    Done <= (mode == 2) || (mode == 1 && Init && (run_cyc + 1 == done_at));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press();
    Btn_n = 1'b0;
    repeat (24) @(negedge Clk);
    Btn_n = 1'b1;
    repeat (24) @(negedge Clk);
  endtask

  task automatic wait_init();
    int k;
    for (k = 0; k < 40 && !Init; k++) @(negedge Clk);
    check("run_entry_bound", 32'(Init), 32'd1);
  endtask

  initial begin
    vecs[0] = '{4'h9, 4'h3, 2'b10, 8'h1B, 1'b0, 1, 6,  3'd4, 6};
    vecs[1] = '{4'hF, 4'h1, 2'b00, 8'h10, 1'b1, 2, 0,  3'd4, 2};
    vecs[2] = '{4'h5, 4'hA, 2'b11, 8'h55, 1'b1, 0, 0,  3'd5, 64};
    vecs[3] = '{4'h2, 4'h7, 2'b01, 8'hE0, 1'b0, 1, 64, 3'd4, 64};
    vecs[4] = '{4'hC, 4'hC, 2'b10, 8'h99, 1'b1, 1, 1,  3'd5, 64};
    vecs[5] = '{4'h0, 4'hF, 2'b01, 8'h0F, 1'b0, 1, 2,  3'd4, 2};
    vecs[6] = '{4'h3, 4'h3, 2'b00, 8'h77, 1'b1, 1, 65, 3'd5, 64};

    exp_res  = 8'h00;
    exp_cout = 1'b0;
    Rst_n    = 1'b0;
    Btn_n    = 1'b1;
    Sw       = 4'h0;
    Sel_sw   = 2'b00;
    Alu_sal  = 8'h00;
    Alu_cout = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_state", 32'(State), 32'd0);
    check("rst_a", 32'(A), 32'd0);
    check("rst_b", 32'(B), 32'd0);
    check("rst_select", 32'(Select), 32'd0);
    check("rst_init", 32'(Init), 32'd0);
    check("rst_result", 32'(Result), 32'd0);
    check("rst_result_cout", 32'(Result_cout), 32'd0);
    check("rst_valid", 32'(Result_valid), 32'd0);
    check("rst_error", 32'(Error), 32'd0);
    Rst_n = 1'b1;
    repeat (100) @(negedge Clk);
    check("idle_hold_state", 32'(State), 32'd0);

    Btn_n = 1'b0;
    repeat (5) @(negedge Clk);
    Btn_n = 1'b1;
    repeat (40) @(negedge Clk);
    check("glitch_state", 32'(State), 32'd0);

    for (int i = 0; i < 7; i++) begin
      int k;
      mode     = vecs[i].mode;
      done_at  = vecs[i].done_at;
      Alu_sal  = vecs[i].sal;
      Alu_cout = vecs[i].cout;
      Sw = vecs[i].a;
      press();
      Sw = vecs[i].b;
      press();
      Sel_sw = vecs[i].sel;
      Sw = ~vecs[i].b;
      press();
      for (k = 0; k < 150 && (Init || State == 3'd3); k++) @(negedge Clk);
      check("run_end_bound", 32'(k < 150), 32'd1);
      @(negedge Clk);
      if (vecs[i].exp_state == 3'd4) begin
        exp_res  = vecs[i].sal;
        exp_cout = vecs[i].cout;
      end
      check("end_state", 32'(State), 32'(vecs[i].exp_state));
      check("a", 32'(A), 32'(vecs[i].a));
      check("b", 32'(B), 32'(vecs[i].b));
      check("select", 32'(Select), 32'(vecs[i].sel));
      check("init_after_run", 32'(Init), 32'd0);
      check("result", 32'(Result), 32'(exp_res));
      check("result_cout", 32'(Result_cout), 32'(exp_cout));
      check("valid", 32'(Result_valid), 32'(vecs[i].exp_state == 3'd4));
      check("error", 32'(Error), 32'(vecs[i].exp_state == 3'd5));
      check("run_len", 32'(run_cyc), 32'(vecs[i].exp_len));
      press();
      check("back_idle_state", 32'(State), 32'd0);
      check("back_idle_valid", 32'(Result_valid), 32'd0);
      check("back_idle_error", 32'(Error), 32'd0);
      check("back_idle_result", 32'(Result), 32'(exp_res));
    end

    begin
      int k;
      mode = 0;
      Sw = 4'h1;
      press();
      Sw = 4'h2;
      press();
      Sel_sw = 2'b11;
      Btn_n = 1'b0;
      wait_init();
      check("run_state", 32'(State), 32'd3);
      check("run_a", 32'(A), 32'd1);
      check("run_b", 32'(B), 32'd2);
      check("run_select", 32'(Select), 32'd3);
      Btn_n = 1'b1;
      repeat (24) @(negedge Clk);
      Btn_n = 1'b0;
      repeat (24) @(negedge Clk);
      check("press_in_run_state", 32'(State), 32'd3);
      check("press_in_run_init", 32'(Init), 32'd1);
      Btn_n = 1'b1;
      for (k = 0; k < 80 && State == 3'd3; k++) @(negedge Clk);
      check("err_state", 32'(State), 32'd5);
      check("err_flag", 32'(Error), 32'd1);
      check("err_init", 32'(Init), 32'd0);
      check("err_result", 32'(Result), 32'(exp_res));
      repeat (24) @(negedge Clk);
      check("err_hold_state", 32'(State), 32'd5);
      press();
      check("err_clear_state", 32'(State), 32'd0);
      check("err_clear_flag", 32'(Error), 32'd0);
    end

    Sw = 4'h4;
    press();
    Sw = 4'h5;
    press();
    Btn_n = 1'b0;
    wait_init();
    repeat (3) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("rst_run_init", 32'(Init), 32'd0);
    check("rst_run_state", 32'(State), 32'd0);
    check("rst_run_valid", 32'(Result_valid), 32'd0);
    check("rst_run_result", 32'(Result), 32'd0);
    check("rst_run_a", 32'(A), 32'd0);
    Btn_n = 1'b1;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (30) @(negedge Clk);
    check("post_rst_state", 32'(State), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
